// File: rtl/digital_tube_scan_ctrl.sv
// Six-digit seven-segment scan controller.
// Snapshots the display number once per frame, then lights one digit per slot
// with an all-off dead-time gap before each digit to suppress ghosting.
// Provides hex glyph decode, optional leading-zero blanking and a frame-done strobe.
module digital_tube_scan_ctrl #(
  parameter int BLANK_CYCLES   = 500,
  parameter int ON_CYCLES      = 49500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        display_enable,
  input  logic [23:0] display_num,
  input  logic        lz_blank,
  output logic [7:0]  seg,
  output logic [5:0]  sel,
  output logic        frame_done,
  output logic        busy
);

  // Slot counter only ever holds (cycles - 1) of the longer slot.
  localparam int MAX_CYCLES = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);

  // "Off" levels after polarity is applied.
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0] SEL_OFF = SEL_ACTIVE_LOW ? 6'h3F : 6'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_BLANK = 2'd2,
    S_ON    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [23:0]      frame_q, frame_d;
  logic             lzb_q, lzb_d;

  logic [7:0]       seg_q, seg_d;
  logic [5:0]       sel_q, sel_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [6:0]       seg_raw;
  logic [5:0]       sel_raw;
  logic [5:0]       blank_mask;
  logic [3:0]       cur_nibble;

  // Hex glyph decode, active-high, bit order g..a.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase
    return code;
  endfunction

  // Selects the nibble for digit idx; out-of-range indices read as zero.
  function automatic logic [3:0] nibble_at(input logic [23:0] frame, input logic [2:0] idx);
    logic [3:0] nib;
    case (idx)
      3'd0: nib = frame[3:0];
      3'd1: nib = frame[7:4];
      3'd2: nib = frame[11:8];
      3'd3: nib = frame[15:12];
      3'd4: nib = frame[19:16];
      3'd5: nib = frame[23:20];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // Bit i set when digit i and every digit above it are zero; digit0 never set.
  function automatic logic [5:0] lz_mask(input logic [23:0] frame);
    logic [5:0] m;
    logic       above_zero;
    m          = 6'b000000;
    above_zero = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      above_zero = above_zero & (frame[4*i +: 4] == 4'h0);
      m[i]       = above_zero;
    end
    return m;
  endfunction

  // Next-state logic and registered-output precompute from the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    lzb_d      = lzb_q;
    done_d     = 1'b0;
    seg_raw    = 7'h00;
    sel_raw    = 6'h00;
    blank_mask = 6'h00;
    cur_nibble = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (display_enable) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        frame_d = display_num;
        lzb_d   = lz_blank;
        idx_d   = 3'd0;
        state_d = S_BLANK;
        cnt_d   = BLANK_LOAD;
      end
      S_BLANK: begin
        if (cnt_q == '0) begin
          state_d = S_ON;
          cnt_d   = ON_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          if (idx_q == 3'd5) begin
            // A completed frame is reported even if enable drops on this edge.
            done_d  = 1'b1;
            state_d = S_LOAD;
            cnt_d   = '0;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_BLANK;
            cnt_d   = BLANK_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Losing enable abandons the frame from any active state.
    if (!display_enable && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    // Outputs reflect the state being entered so they change on the entry edge.
    if (state_d == S_ON) begin
      sel_raw    = 6'b000001 << idx_d;
      blank_mask = lz_mask(frame_d);
      cur_nibble = nibble_at(frame_d, idx_d);
      if (!(lzb_d && blank_mask[idx_d])) begin
        seg_raw = seg_decode(cur_nibble);
      end
    end

    seg_d  = SEG_ACTIVE_LOW ? ~{1'b0, seg_raw} : {1'b0, seg_raw};
    sel_d  = SEL_ACTIVE_LOW ? ~sel_raw : sel_raw;
    busy_d = (state_d != S_IDLE);
  end

  // State, frame snapshot and registered outputs; async reset forces all-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      frame_q <= 24'h000000;
      lzb_q   <= 1'b0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      lzb_q   <= lzb_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_digital_tube_scan_ctrl.sv
// Bench for digital_tube_scan_ctrl with BLANK_CYCLES=2, ON_CYCLES=4, active-low
// segment and select. Full frames come from a vector table; enable drop,
// mid-frame number change and async reset are hand-written sequences.
module tb_digital_tube_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        display_enable;
  logic [23:0] display_num;
  logic        lz_blank;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame_done;
  logic        busy;

  int nchk  = 0;
  int nfail = 0;

  typedef struct packed {
    logic [23:0] num;
    logic        lz;
    logic [47:0] segs;   // {digit5, ..., digit0}, active-low codes
  } vec_t;

  vec_t vecs [6];

  digital_tube_scan_ctrl #(
    .BLANK_CYCLES  (2),
    .ON_CYCLES     (4),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .display_enable(display_enable),
    .display_num   (display_num),
    .lz_blank      (lz_blank),
    .seg           (seg),
    .sel           (sel),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] esel, input logic [7:0] eseg,
                       input logic ebusy, input logic efd);
    nchk++;
    if (sel !== esel || seg !== eseg || busy !== ebusy || frame_done !== efd) begin
      nfail++;
      $display("FAIL %s: got sel=%h seg=%h busy=%b frame_done=%b, want sel=%h seg=%h busy=%b frame_done=%b",
               name, sel, seg, busy, frame_done, esel, eseg, ebusy, efd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic blank_phase(input int d);
    repeat (2) begin
      step();
      check($sformatf("digit%0d blank", d), 6'h3F, 8'hFF, 1'b1, 1'b0);
    end
  endtask

  task automatic on_phase(input int d, input logic [7:0] segv, input int n);
    logic [5:0] s;
    s = 6'h3F ^ (6'b000001 << d);
    repeat (n) begin
      step();
      check($sformatf("digit%0d on", d), s, segv, 1'b1, 1'b0);
    end
  endtask

  task automatic frame_end();
    step();
    check("frame_done at load", 6'h3F, 8'hFF, 1'b1, 1'b1);
  endtask

  task automatic go_idle();
    display_enable = 1'b0;
    step();
    check("return to idle", 6'h3F, 8'hFF, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{num: 24'h123456, lz: 1'b0, segs: {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
    vecs[1] = '{num: 24'h000070, lz: 1'b1, segs: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0}};
    vecs[2] = '{num: 24'h000000, lz: 1'b1, segs: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{num: 24'h00ABCD, lz: 1'b0, segs: {8'hC0, 8'hC0, 8'h88, 8'h83, 8'hC6, 8'hA1}};
    vecs[4] = '{num: 24'h00ABCD, lz: 1'b1, segs: {8'hFF, 8'hFF, 8'h88, 8'h83, 8'hC6, 8'hA1}};
    vecs[5] = '{num: 24'hF0E009, lz: 1'b1, segs: {8'h8E, 8'hC0, 8'h86, 8'hC0, 8'hC0, 8'h90}};

    rst_n          = 1'b0;
    display_enable = 1'b0;
    display_num    = 24'h000000;
    lz_blank       = 1'b0;

    // Reset state, then idle hold with enable low.
    repeat (3) @(posedge clk);
    #1;
    check("reset values", 6'h3F, 8'hFF, 1'b0, 1'b0);
    rst_n       = 1'b1;
    display_num = 24'h888888;
    repeat (3) begin
      step();
      check("idle hold", 6'h3F, 8'hFF, 1'b0, 1'b0);
    end

    // Table-driven full frames.
    for (int i = 0; i < 6; i++) begin
      display_num    = vecs[i].num;
      lz_blank       = vecs[i].lz;
      display_enable = 1'b1;
      step();
      check($sformatf("vec%0d load", i), 6'h3F, 8'hFF, 1'b1, 1'b0);
      for (int d = 0; d < 6; d++) begin
        blank_phase(d);
        on_phase(d, vecs[i].segs[8*d +: 8], 4);
      end
      frame_end();
      go_idle();
    end

    // Number changes during digit2 ON: current frame keeps the snapshot.
    display_num    = 24'h111111;
    lz_blank       = 1'b0;
    display_enable = 1'b1;
    step();
    check("snap load", 6'h3F, 8'hFF, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      blank_phase(d);
      on_phase(d, 8'hF9, 4);
    end
    blank_phase(2);
    on_phase(2, 8'hF9, 1);
    display_num = 24'h222222;
    on_phase(2, 8'hF9, 3);
    for (int d = 3; d < 6; d++) begin
      blank_phase(d);
      on_phase(d, 8'hF9, 4);
    end
    frame_end();
    for (int d = 0; d < 6; d++) begin
      blank_phase(d);
      on_phase(d, 8'hA4, 4);
    end
    frame_end();
    go_idle();

    // Enable drops during digit3 ON: immediate idle, no frame_done.
    display_num    = 24'h123456;
    lz_blank       = 1'b0;
    display_enable = 1'b1;
    step();
    check("drop load", 6'h3F, 8'hFF, 1'b1, 1'b0);
    blank_phase(0); on_phase(0, 8'h82, 4);
    blank_phase(1); on_phase(1, 8'h92, 4);
    blank_phase(2); on_phase(2, 8'h99, 4);
    blank_phase(3); on_phase(3, 8'hB0, 2);
    display_enable = 1'b0;
    step();
    check("enable dropped", 6'h3F, 8'hFF, 1'b0, 1'b0);
    repeat (3) begin
      step();
      check("dropped stays idle", 6'h3F, 8'hFF, 1'b0, 1'b0);
    end
    display_enable = 1'b1;
    step();
    check("re-enable load", 6'h3F, 8'hFF, 1'b1, 1'b0);
    blank_phase(0); on_phase(0, 8'h82, 4);
    blank_phase(1); on_phase(1, 8'h92, 1);

    // Async reset while a digit is lit.
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset mid-on", 6'h3F, 8'hFF, 1'b0, 1'b0);
    step();
    check("held in reset", 6'h3F, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check("restart load", 6'h3F, 8'hFF, 1'b1, 1'b0);

    // Async reset in the middle of a blank slot.
    step();
    check("digit0 blank before reset", 6'h3F, 8'hFF, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset mid-blank", 6'h3F, 8'hFF, 1'b0, 1'b0);
    step();
    check("held in reset 2", 6'h3F, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check("restart load 2", 6'h3F, 8'hFF, 1'b1, 1'b0);
    blank_phase(0); on_phase(0, 8'h82, 4);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
